// File: rtl/dds_axil_pkg.sv
// Shared constants and helpers for the DDS AXI4-Lite register bank.
package dds_axil_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_FTW  = 2'd1;
  localparam logic [1:0] REG_POFF = 2'd2;
  localparam logic [1:0] REG_AMP  = 2'd3;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Byte-lane merge: lanes with strb set take new_val, others keep old_val.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with level-sensitive clear and registered offset adder.
module dds_phase_acc
  import dds_axil_pkg::*;
#(
  parameter int PHASE_WIDTH = 32
) (
  input  logic                   clk_sys,
  input  logic                   rst_b,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  input  logic [PHASE_WIDTH-1:0] ftw,
  input  logic [PHASE_WIDTH-1:0] poff,
  output logic [PHASE_WIDTH-1:0] phase
);

  logic [PHASE_WIDTH-1:0] acc;

  // Accumulate the tuning word each cycle; clear wins over enable and wraps silently.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + ftw;
    end
  end

  // Output phase trails the accumulator by one cycle.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      phase <= '0;
    end else begin
      phase <= acc + poff;
    end
  end

endmodule

// File: rtl/dds_axil_regs.sv
// AXI4-Lite slave register bank for the DDS core: CTRL/FTW/POFF/AMP plus the
// phase accumulator driven from them.
module dds_axil_regs
  import dds_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PHASE_WIDTH        = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [PHASE_WIDTH-1:0]          dds_phase,
  output logic [15:0]                     dds_amp,
  output logic                            dds_en
);

  logic [31:0] regs [NUM_REGS];

  // Write-side holding registers: AW and W may arrive in any order.
  logic        aw_full;
  logic [1:0]  aw_idx_q;
  logic        w_full;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q;

  logic        aw_hs;
  logic        w_hs;
  logic        wr_commit;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = !aw_full;
  assign S_AXI_WREADY  = !w_full;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = AXI_RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;

  assign aw_hs = S_AXI_AWVALID && !aw_full;
  assign w_hs  = S_AXI_WVALID && !w_full;

  // Live channel bypasses an empty holding register so same-cycle AW+W commits at once.
  always_comb begin
    wr_idx    = aw_full ? aw_idx_q : S_AXI_AWADDR[3:2];
    wr_data   = w_full  ? w_data_q : S_AXI_WDATA;
    wr_strb   = w_full  ? w_strb_q : S_AXI_WSTRB;
    wr_commit = (aw_full || aw_hs) && (w_full || w_hs) && (!bvalid_q || S_AXI_BREADY);
  end

  // Capture AW/W into their holding registers; both empty again on commit.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full  <= 1'b0;
      aw_idx_q <= '0;
      w_full   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (wr_commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (aw_hs) aw_full <= 1'b1;
        if (w_hs)  w_full  <= 1'b1;
      end
    end
  end

  // Register file update with byte strobes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      regs[wr_idx] <= apply_wstrb(regs[wr_idx], wr_data, wr_strb);
    end
  end

  // Write response: a commit (re)asserts BVALID, otherwise BREADY retires it.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bvalid_q <= 1'b0;
    end else if (wr_commit) begin
      bvalid_q <= 1'b1;
    end else if (S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read channel: one outstanding read; RDATA sampled before any same-cycle commit.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else if (S_AXI_ARVALID && arready_q) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= regs[S_AXI_ARADDR[3:2]];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end
  end

  assign dds_en  = regs[REG_CTRL][CTRL_EN_BIT];
  assign dds_amp = regs[REG_AMP][15:0];

  dds_phase_acc #(
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_phase_acc (
    .clk_sys (S_AXI_ACLK),
    .rst_b   (S_AXI_ARESETN),
    .acc_en  (regs[REG_CTRL][CTRL_EN_BIT]),
    .acc_clr (regs[REG_CTRL][CTRL_CLR_BIT]),
    .ftw     (regs[REG_FTW][PHASE_WIDTH-1:0]),
    .poff    (regs[REG_POFF][PHASE_WIDTH-1:0]),
    .phase   (dds_phase)
  );

endmodule

// File: tb/tb_dds_axil_regs.sv
// Randomized self-checking bench for dds_axil_regs against a register-array model.
module tb_dds_axil_regs;

  localparam int TMO = 50;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] dds_phase;
  logic [15:0] dds_amp;
  logic        dds_en;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [4];

  dds_axil_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .dds_phase     (dds_phase),
    .dds_amp       (dds_amp),
    .dds_en        (dds_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  task automatic drive_aw(input logic [3:0] addr, input int dly);
    int n;
    n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = addr; awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < TMO);
    check_val("aw_ready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    int n;
    n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = data; wstrb = strb; wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!wready && n < TMO);
    check_val("w_ready", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_aw_w(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly);
    @(posedge clk); #1;
    fork
      begin
        drive_aw(addr, aw_dly);
        if (w_dly > aw_dly) begin @(negedge clk); check_val("aw_hold", awready, 0); end
      end
      begin
        drive_w(data, strb, w_dly);
        if (aw_dly > w_dly) begin @(negedge clk); check_val("w_hold", wready, 0); end
      end
    join
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < TMO);
    check_val("bvalid", bvalid, 1);
    check_val("bresp", bresp, 0);
  endtask

  task automatic ack_b(input int dly);
    repeat (dly) begin @(negedge clk); check_val("b_hold", bvalid, 1); end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    send_aw_w(addr, data, strb, aw_dly, w_dly);
    wait_b();
    ack_b(b_dly);
    m_regs[addr[3:2]] = merge(m_regs[addr[3:2]], data, strb);
    @(negedge clk);
    check_val("b_drop", bvalid, 0);
    check_val("dds_en", dds_en, m_regs[0][0]);
    check_val("dds_amp", dds_amp, m_regs[3][15:0]);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int rr_dly, output logic [31:0] data);
    int n;
    n = 0;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < TMO);
    check_val("ar_ready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < TMO) begin @(negedge clk); n++; end
    check_val("rvalid", rvalid, 1);
    check_val("rresp", rresp, 0);
    check_val("ar_low", arready, 0);
    data = rdata;
    repeat (rr_dly) @(negedge clk);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    check_val("ar_back", arready, 1);
    check_val("r_drop", rvalid, 0);
  endtask

  task automatic read_chk(input logic [3:0] addr, input int rr_dly);
    logic [31:0] d;
    axi_read(addr, rr_dly, d);
    check_val("rdata", d, m_regs[addr[3:2]]);
  endtask

  initial begin
    logic [31:0] d, prev, ftw, poff;
    int n;

    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_awready", awready, 1);
    check_val("rst_wready", wready, 1);
    check_val("rst_arready", arready, 1);
    check_val("rst_bvalid", bvalid, 0);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_phase", dds_phase, 0);
    check_val("rst_amp", dds_amp, 0);
    check_val("rst_en", dds_en, 0);
    rst_n = 1'b1;

    // sequential writes then reads
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) read_chk(4'(i * 4), 0);

    // W three cycles ahead of AW
    axi_write(4'h4, 32'hA5A5_A5A5, 4'hF, 3, 0, 0);
    read_chk(4'h4, 1);

    // byte-strobe merge on AMP
    axi_write(4'hC, 32'h1234_5678, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'b0010, 0, 2, 0);
    read_chk(4'hC, 0);
    check_val("amp_merge", dds_amp, 16'hFF78);

    // second write stalls behind an unacknowledged response
    send_aw_w(4'h4, 32'h1111_2222, 4'hF, 0, 0);
    wait_b();
    send_aw_w(4'h8, 32'h3333_4444, 4'hF, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("stall_bvalid", bvalid, 1);
      check_val("stall_awready", awready, 0);
      check_val("stall_wready", wready, 0);
    end
    axi_read(4'h8, 0, d);
    check_val("stall_no_commit", d, m_regs[2]);
    ack_b(0);
    m_regs[1] = 32'h1111_2222;
    wait_b();
    ack_b(0);
    m_regs[2] = 32'h3333_4444;
    @(negedge clk);
    check_val("stall_b_drop", bvalid, 0);
    read_chk(4'h4, 0);
    read_chk(4'h8, 2);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1, 0) == 1)
        axi_write(4'($urandom), $urandom, 4'($urandom), $urandom_range(3, 0),
                  $urandom_range(3, 0), $urandom_range(3, 0));
      else
        read_chk(4'($urandom), $urandom_range(3, 0));
    end

    // directed phase sequence with wrap, then clear
    axi_write(4'h0, 32'h2, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'h4000_0000, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'h0000_0010, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (dds_phase !== 32'h4000_0010 && n < 10);
    check_val("phase_0", dds_phase, 32'h4000_0010);
    @(negedge clk); check_val("phase_1", dds_phase, 32'h8000_0010);
    @(negedge clk); check_val("phase_2", dds_phase, 32'hC000_0010);
    @(negedge clk); check_val("phase_wrap", dds_phase, 32'h0000_0010);
    axi_write(4'h0, 32'h3, 4'hF, 0, 0, 0);
    read_chk(4'h0, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("phase_clr", dds_phase, 32'h0000_0010);
    end

    // random tuning word and offset: per-cycle step equals FTW, clear yields POFF
    ftw  = $urandom;
    poff = $urandom;
    axi_write(4'h4, ftw, 4'hF, 0, 0, 0);
    axi_write(4'h8, poff, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
    @(negedge clk);
    prev = dds_phase;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("phase_step", dds_phase, prev + ftw);
      prev = dds_phase;
    end
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, 0);
    @(negedge clk);
    prev = dds_phase;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("phase_hold", dds_phase, prev);
    end
    axi_write(4'h0, 32'h2, 4'hF, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_val("phase_clr_rand", dds_phase, poff);

    // reset with AW accepted and W pending
    @(posedge clk); #1;
    awaddr = 4'h4; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < TMO);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check_val("mid_aw_held", awready, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("post_rst_bvalid", bvalid, 0);
    end
    check_val("post_rst_awready", awready, 1);
    check_val("post_rst_wready", wready, 1);
    check_val("post_rst_phase", dds_phase, 0);
    check_val("post_rst_en", dds_en, 0);
    for (int i = 0; i < 4; i++) read_chk(4'(i * 4), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
